// File: rtl/det_event_logger_if.sv
// Bundle between det_event_logger and its detector/reader.
// Carries the detection strobe, the clear, and the timestamp read port.
interface det_event_logger_if #(
  parameter int TS_W  = 16,
  parameter int CNT_W = 8
);
  logic             det;
  logic             clr;
  logic             ev_ready;
  logic             ev_valid;
  logic [TS_W-1:0]  ev_ts;
  logic [CNT_W-1:0] ev_cnt;
  logic             full;
  logic             ovf;

  // An entry transfers at a rising edge where ev_valid and ev_ready are both 1.
  // ev_valid never depends on ev_ready. While ev_valid is 1 and ev_ready is 0,
  // ev_ts holds steady.
  modport master (
    output det, clr, ev_ready,
    input  ev_valid, ev_ts, ev_cnt, full, ovf
  );

  modport slave (
    input  det, clr, ev_ready,
    output ev_valid, ev_ts, ev_cnt, full, ovf
  );
endinterface

// File: rtl/det_event_logger.sv
// Timestamps detector strobes into a first-word-fall-through FIFO and counts them.
// Optional macro DET_EDGE_EN: qualify det on its rising edge only.
module det_event_logger #(
  parameter int TS_W  = 16,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  det_event_logger_if.slave bus,
  output logic [1:0]       dbg_state_o,
  output logic [TS_W-1:0]  dbg_ts_o
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_PARTIAL = 2'd1,
    ST_FULL    = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    wr_ptr_inc, rd_ptr_inc;
  logic [TS_W-1:0]  ts_q, ts_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [TS_W-1:0]  mem_q [DEPTH];

  logic det_qual;
  logic event_w;
  logic pop_w;
  logic wr_en;
  logic drop_w;

`ifdef DET_EDGE_EN
  logic det_q, det_d;

  always_comb det_d = bus.clr ? 1'b0 : bus.det;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) det_q <= 1'b0;
    else     det_q <= det_d;
  end

  assign det_qual = bus.det & ~det_q;
`else
  assign det_qual = bus.det;
`endif

  // clr masks both sides of the FIFO so a coincident strobe or pop is discarded.
  assign event_w    = det_qual & ~bus.clr;
  assign pop_w      = (state_q != ST_EMPTY) & bus.ev_ready & ~bus.clr;
  assign wr_en      = event_w & ((state_q != ST_FULL) | pop_w);
  assign drop_w     = event_w & (state_q == ST_FULL) & ~pop_w;
  assign wr_ptr_inc = wr_ptr_q + PW'(1);
  assign rd_ptr_inc = rd_ptr_q + PW'(1);

  always_comb begin
    state_d = state_q;
    if (bus.clr) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (wr_en) state_d = ST_PARTIAL;
        end
        ST_PARTIAL: begin
          if (wr_en && !pop_w && (wr_ptr_inc == rd_ptr_q))
            state_d = ST_FULL;
          else if (pop_w && !wr_en && (rd_ptr_inc == wr_ptr_q))
            state_d = ST_EMPTY;
        end
        ST_FULL: begin
          if (pop_w && !wr_en) state_d = ST_PARTIAL;
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    ts_d     = ts_q + TS_W'(1);
    if (bus.clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
      ovf_d    = 1'b0;
      ts_d     = '0;
    end else begin
      if (wr_en)  wr_ptr_d = wr_ptr_inc;
      if (pop_w)  rd_ptr_d = rd_ptr_inc;
      if (event_w && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);
      if (drop_w) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_EMPTY;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ts_q     <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ts_q     <= ts_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage is cleared on reset so ev_ts reads 0 straight out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_en) begin
      mem_q[wr_ptr_q] <= ts_q;
    end
  end

  assign bus.ev_valid = (state_q != ST_EMPTY);
  assign bus.full     = (state_q == ST_FULL);
  assign bus.ev_ts    = mem_q[rd_ptr_q];
  assign bus.ev_cnt   = cnt_q;
  assign bus.ovf      = ovf_q;
  assign dbg_state_o  = state_q;
  assign dbg_ts_o     = ts_q;
endmodule

// File: tb/tb_det_event_logger.sv
// Self-checking bench for det_event_logger: directed scenarios plus a randomized
// run against a queue-based reference model; a small-width instance covers wrap/saturation.
module tb_det_event_logger;
  localparam int TS_W    = 16;
  localparam int DEPTH   = 4;
  localparam int CNT_W   = 8;
  localparam int S_TS_W  = 4;
  localparam int S_CNT_W = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  det_event_logger_if #(.TS_W(TS_W),   .CNT_W(CNT_W))   bus();
  det_event_logger_if #(.TS_W(S_TS_W), .CNT_W(S_CNT_W)) sbus();

  logic [1:0]        dbg_state;
  logic [1:0]        s_dbg_state;
  logic [TS_W-1:0]   dbg_ts;
  logic [S_TS_W-1:0] s_dbg_ts;

  det_event_logger #(.TS_W(TS_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .dbg_state_o (dbg_state),
    .dbg_ts_o    (dbg_ts)
  );

  det_event_logger #(.TS_W(S_TS_W), .DEPTH(4), .CNT_W(S_CNT_W)) u_small (
    .clk         (clk),
    .rst         (rst),
    .bus         (sbus),
    .dbg_state_o (s_dbg_state),
    .dbg_ts_o    (s_dbg_ts)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: timestamp counter, queue of pending timestamps, counters.
  logic [TS_W-1:0] m_ts;
  int unsigned     m_q[$];
  int              m_cnt;
  bit              m_ovf;
  bit              m_prev;

  task automatic model_reset();
    m_q.delete();
    m_ts   = '0;
    m_cnt  = 0;
    m_ovf  = 1'b0;
    m_prev = 1'b0;
  endtask

  task automatic model_step(input bit d, input bit c, input bit r);
    bit ev;
    bit pop;
`ifdef DET_EDGE_EN
    ev = d && !m_prev && !c;
`else
    ev = d && !c;
`endif
    m_prev = c ? 1'b0 : d;
    if (c) begin
      m_q.delete();
      m_cnt = 0;
      m_ovf = 1'b0;
      m_ts  = '0;
    end else begin
      pop = (m_q.size() > 0) && r;
      if (pop) void'(m_q.pop_front());
      if (ev) begin
        if (m_q.size() == DEPTH) m_ovf = 1'b1;
        else m_q.push_back(int'(m_ts));
        if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
      end
      m_ts = m_ts + 1'b1;
    end
  endtask

  task automatic step(input bit d, input bit c, input bit r);
    bus.det = d; bus.clr = c; bus.ev_ready = r;
    @(posedge clk);
    model_step(d, c, r);
    #1;
    bus.det = 1'b0; bus.clr = 1'b0; bus.ev_ready = 1'b0;
  endtask

  task automatic sstep(input bit d, input bit c, input bit r);
    sbus.det = d; sbus.clr = c; sbus.ev_ready = r;
    @(posedge clk);
    #1;
    sbus.det = 1'b0; sbus.clr = 1'b0; sbus.ev_ready = 1'b0;
  endtask

  task automatic do_reset();
    bus.det = 1'b0; bus.clr = 1'b0; bus.ev_ready = 1'b0;
    sbus.det = 1'b0; sbus.clr = 1'b0; sbus.ev_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (bus.ev_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b want=0", bus.ev_valid); end
    total++; if (bus.full !== 1'b0) begin bad++; $display("FAIL reset_full got=%0b want=0", bus.full); end
    total++; if (bus.ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%0b want=0", bus.ovf); end
    total++; if (bus.ev_cnt !== '0) begin bad++; $display("FAIL reset_cnt got=%0d want=0", bus.ev_cnt); end
    total++; if (bus.ev_ts !== '0) begin bad++; $display("FAIL reset_ev_ts got=%0d want=0", bus.ev_ts); end
    total++; if (dbg_ts !== '0) begin bad++; $display("FAIL reset_ts got=%0d want=0", dbg_ts); end
  endtask

  task automatic test_basic();
    do_reset();
    while (m_ts != 16'd8) step((m_ts == 16'd3) || (m_ts == 16'd7), 1'b0, 1'b0);
    total++; if (bus.ev_valid !== 1'b1) begin bad++; $display("FAIL basic_valid got=%0b want=1", bus.ev_valid); end
    total++; if (bus.ev_ts !== 16'd3) begin bad++; $display("FAIL basic_head0 got=%0d want=3", bus.ev_ts); end
    step(1'b0, 1'b0, 1'b1);
    total++; if (bus.ev_ts !== 16'd7 || bus.ev_valid !== 1'b1) begin bad++; $display("FAIL basic_head1 got=%0d/%0b want=7/1", bus.ev_ts, bus.ev_valid); end
    step(1'b0, 1'b0, 1'b1);
    total++; if (bus.ev_valid !== 1'b0) begin bad++; $display("FAIL basic_empty got=%0b want=0", bus.ev_valid); end
    total++; if (bus.ev_cnt !== 8'd2) begin bad++; $display("FAIL basic_cnt got=%0d want=2", bus.ev_cnt); end
  endtask

  task automatic test_overflow();
    int exp_a[4] = '{1, 3, 5, 7};
    do_reset();
    while (m_ts != 16'd10) begin
      step(m_ts[0] && (m_ts <= 16'd9), 1'b0, 1'b0);
      if (m_ts == 16'd8) begin
        total++; if (bus.full !== 1'b1 || bus.ovf !== 1'b0) begin bad++; $display("FAIL ovf_fill got full=%0b ovf=%0b want 1/0", bus.full, bus.ovf); end
      end
    end
    total++; if (bus.ovf !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%0b want=1", bus.ovf); end
    total++; if (bus.ev_cnt !== 8'd5) begin bad++; $display("FAIL ovf_cnt got=%0d want=5", bus.ev_cnt); end
    for (int i = 0; i < 4; i++) begin
      total++; if (bus.ev_valid !== 1'b1 || bus.ev_ts !== TS_W'(exp_a[i])) begin bad++; $display("FAIL ovf_drain%0d got=%0d/%0b want=%0d/1", i, bus.ev_ts, bus.ev_valid, exp_a[i]); end
      step(1'b0, 1'b0, 1'b1);
    end
    total++; if (bus.ev_valid !== 1'b0 || bus.ovf !== 1'b1) begin bad++; $display("FAIL ovf_after got valid=%0b ovf=%0b want 0/1", bus.ev_valid, bus.ovf); end
  endtask

  task automatic test_back_to_back();
    int exp_a[4] = '{2, 4, 6, 8};
    do_reset();
    while (m_ts != 16'd8) step(!m_ts[0], 1'b0, 1'b0);
    total++; if (bus.full !== 1'b1) begin bad++; $display("FAIL b2b_full got=%0b want=1", bus.full); end
    step(1'b1, 1'b0, 1'b1);
    total++; if (bus.full !== 1'b1 || bus.ovf !== 1'b0) begin bad++; $display("FAIL b2b_flags got full=%0b ovf=%0b want 1/0", bus.full, bus.ovf); end
    total++; if (bus.ev_cnt !== 8'd5) begin bad++; $display("FAIL b2b_cnt got=%0d want=5", bus.ev_cnt); end
    for (int i = 0; i < 4; i++) begin
      total++; if (bus.ev_valid !== 1'b1 || bus.ev_ts !== TS_W'(exp_a[i])) begin bad++; $display("FAIL b2b_drain%0d got=%0d want=%0d", i, bus.ev_ts, exp_a[i]); end
      step(1'b0, 1'b0, 1'b1);
    end
    total++; if (bus.ev_valid !== 1'b0) begin bad++; $display("FAIL b2b_empty got=%0b want=0", bus.ev_valid); end
  endtask

  task automatic test_clr();
    do_reset();
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    total++; if (bus.ev_cnt !== 8'd2 || bus.ev_valid !== 1'b1) begin bad++; $display("FAIL clr_pre got cnt=%0d valid=%0b want 2/1", bus.ev_cnt, bus.ev_valid); end
    step(1'b1, 1'b1, 1'b1);
    total++; if (bus.ev_valid !== 1'b0 || bus.full !== 1'b0) begin bad++; $display("FAIL clr_fifo got valid=%0b full=%0b want 0/0", bus.ev_valid, bus.full); end
    total++; if (bus.ev_cnt !== 8'd0 || bus.ovf !== 1'b0) begin bad++; $display("FAIL clr_cnt got cnt=%0d ovf=%0b want 0/0", bus.ev_cnt, bus.ovf); end
    total++; if (dbg_ts !== 16'd0) begin bad++; $display("FAIL clr_ts got=%0d want=0", dbg_ts); end
    step(1'b0, 1'b0, 1'b0);
    total++; if (dbg_ts !== 16'd1 || bus.ev_valid !== 1'b0) begin bad++; $display("FAIL clr_post got ts=%0d valid=%0b want 1/0", dbg_ts, bus.ev_valid); end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 5; i++) step(i % 2 == 0, 1'b0, 1'b0);
    total++; if (bus.ev_cnt !== 8'd3) begin bad++; $display("FAIL areset_pre got=%0d want=3", bus.ev_cnt); end
    #2;
    rst = 1'b1;
    #1;
    total++; if (bus.ev_valid !== 1'b0 || bus.full !== 1'b0) begin bad++; $display("FAIL areset_flags got valid=%0b full=%0b want 0/0", bus.ev_valid, bus.full); end
    total++; if (bus.ev_cnt !== 8'd0 || dbg_ts !== 16'd0) begin bad++; $display("FAIL areset_cnt got cnt=%0d ts=%0d want 0/0", bus.ev_cnt, dbg_ts); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    step(1'b0, 1'b0, 1'b1);
    total++; if (bus.ev_valid !== 1'b0) begin bad++; $display("FAIL areset_post got=%0b want=0", bus.ev_valid); end
  endtask

  task automatic test_det_hold();
    do_reset();
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
`ifdef DET_EDGE_EN
    total++; if (bus.ev_cnt !== 8'd1) begin bad++; $display("FAIL hold_cnt got=%0d want=1", bus.ev_cnt); end
    total++; if (bus.ev_ts !== 16'd0) begin bad++; $display("FAIL hold_head got=%0d want=0", bus.ev_ts); end
    step(1'b0, 1'b0, 1'b1);
    total++; if (bus.ev_valid !== 1'b0) begin bad++; $display("FAIL hold_empty got=%0b want=0", bus.ev_valid); end
`else
    total++; if (bus.ev_cnt !== 8'd3) begin bad++; $display("FAIL hold_cnt got=%0d want=3", bus.ev_cnt); end
    for (int i = 0; i < 3; i++) begin
      total++; if (bus.ev_valid !== 1'b1 || bus.ev_ts !== TS_W'(i)) begin bad++; $display("FAIL hold_head%0d got=%0d want=%0d", i, bus.ev_ts, i); end
      step(1'b0, 1'b0, 1'b1);
    end
    total++; if (bus.ev_valid !== 1'b0) begin bad++; $display("FAIL hold_empty got=%0b want=0", bus.ev_valid); end
`endif
  endtask

  task automatic test_cnt_saturate();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      sstep(1'b1, 1'b0, 1'b0);
      sstep(1'b0, 1'b0, 1'b0);
    end
    total++; if (sbus.ev_cnt !== 2'd3) begin bad++; $display("FAIL sat_cnt got=%0d want=3", sbus.ev_cnt); end
    total++; if (sbus.ovf !== 1'b1 || sbus.full !== 1'b1) begin bad++; $display("FAIL sat_flags got ovf=%0b full=%0b want 1/1", sbus.ovf, sbus.full); end
  endtask

  task automatic test_ts_wrap();
    do_reset();
    for (int i = 0; i < 15; i++) sstep(1'b0, 1'b0, 1'b0);
    sstep(1'b1, 1'b0, 1'b0);
    sstep(1'b1, 1'b0, 1'b0);
    total++; if (s_dbg_ts !== 4'd1) begin bad++; $display("FAIL wrap_ts got=%0d want=1", s_dbg_ts); end
    total++; if (sbus.ev_valid !== 1'b1 || sbus.ev_ts !== 4'd15) begin bad++; $display("FAIL wrap_head0 got=%0d want=15", sbus.ev_ts); end
    sstep(1'b0, 1'b0, 1'b1);
`ifdef DET_EDGE_EN
    total++; if (sbus.ev_valid !== 1'b0) begin bad++; $display("FAIL wrap_empty got=%0b want=0", sbus.ev_valid); end
`else
    total++; if (sbus.ev_valid !== 1'b1 || sbus.ev_ts !== 4'd0) begin bad++; $display("FAIL wrap_head1 got=%0d want=0", sbus.ev_ts); end
`endif
  endtask

  task automatic test_random();
    bit d, c, r;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      d = ($urandom_range(0, 2) != 0);
      c = ($urandom_range(0, 63) == 0);
      if ((i / 60) % 2 == 1) r = ($urandom_range(0, 3) == 0);
      else                   r = ($urandom_range(0, 3) != 0);
      step(d, c, r);
      total++; if (bus.ev_valid !== (m_q.size() != 0)) begin bad++; $display("FAIL rnd_valid cyc=%0d got=%0b want=%0b", i, bus.ev_valid, m_q.size() != 0); end
      total++; if (bus.full !== (m_q.size() == DEPTH)) begin bad++; $display("FAIL rnd_full cyc=%0d got=%0b want=%0b", i, bus.full, m_q.size() == DEPTH); end
      total++; if (bus.ovf !== m_ovf) begin bad++; $display("FAIL rnd_ovf cyc=%0d got=%0b want=%0b", i, bus.ovf, m_ovf); end
      total++; if (bus.ev_cnt !== CNT_W'(m_cnt)) begin bad++; $display("FAIL rnd_cnt cyc=%0d got=%0d want=%0d", i, bus.ev_cnt, m_cnt); end
      total++; if (dbg_ts !== m_ts) begin bad++; $display("FAIL rnd_ts cyc=%0d got=%0d want=%0d", i, dbg_ts, m_ts); end
      if (m_q.size() != 0) begin
        total++; if (bus.ev_ts !== TS_W'(m_q[0])) begin bad++; $display("FAIL rnd_head cyc=%0d got=%0d want=%0d", i, bus.ev_ts, m_q[0]); end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_overflow();
    test_back_to_back();
    test_clr();
    test_async_reset();
    test_det_hold();
    test_cnt_saturate();
    test_ts_wrap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/det_event_logger.md
# det_event_logger

Downstream consumer of the 11010 sequence detector's `det` output. Timestamps each detection with a free-running cycle counter, buffers timestamps in a small FIFO, and presents them to a reader over a valid/ready handshake. Also keeps a saturating total detection count and a sticky overflow flag. It sits between the detector and whatever logs or reports detections.

## Interface
- `TS_W`, 16: timestamp counter width, also the entry width.
- `DEPTH`, 4: FIFO entries; power of two, at least 2.
- `CNT_W`, 8: width of the detection counter.

- `clk` input 1: single clock; all state updates on its rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `det` input 1: detection strobe from the sequence detector, sampled at the rising edge of `clk`.
- `clr` input 1: synchronous clear.
- `ev_ready` input 1: reader accepts the head entry.
- `ev_valid` output 1: the FIFO holds at least one entry.
- `ev_ts` output TS_W: timestamp at the FIFO head.
- `ev_cnt` output CNT_W: total detections, saturating.
- `full` output 1: the FIFO holds `DEPTH` entries.
- `ovf` output 1: sticky flag, set when a detection was dropped.

## Operation
- Timestamp `ts`:
  - Increments by 1 on every edge; wraps from all-ones to 0.
  - Reset and `clr` both set it to 0.
- Event qualification:
  - A detection event occurs at an edge where the qualified `det` is 1 and `clr` is 0.
  - Qualification is set by the macro (see Configuration).
- Push: the value of `ts` before the edge is written to the tail.
- Pop: occurs when `ev_valid` and `ev_ready` are both 1 at the edge; the head advances.
- FIFO control state machine:
  - States: EMPTY, PARTIAL, FULL.
  - EMPTY goes to PARTIAL on push; PARTIAL goes to FULL when a push without a pop reaches `DEPTH` entries.
  - FULL goes to PARTIAL on a pop without a push; PARTIAL goes to EMPTY when a pop without a push leaves 0 entries.
  - Push and pop together leave the occupancy unchanged.
- Outputs by state: `ev_valid` is 1 when the state is not EMPTY; `full` is 1 in FULL.
- Push while FULL with no pop: the entry is dropped and `ovf` is set to 1. `ovf` stays 1 until `clr` or `rst`.
- Push while FULL with a pop in the same edge: both happen, no drop, state stays FULL.
- Pop while EMPTY: ignored.
- `ev_cnt` increments on every event, dropped ones included. It holds at all-ones once it saturates.
- `clr` has priority over everything in the same cycle:
  - FIFO goes to EMPTY; pointers go to 0.
  - `ev_cnt`, `ovf` and `ts` go to 0.
  - A coincident `det` is discarded and a coincident pop has no effect.
- Pointers are `log2(DEPTH)` bits and wrap naturally.
- `ev_ts` is first-word-fall-through: it shows the head whenever `ev_valid` is 1. It is stable while `ev_valid` is 1 and `ev_ready` is 0. Its value is don't-care when EMPTY.

## Timing
- Reset values: `ev_valid` 0, `full` 0, `ovf` 0, `ev_cnt` 0, `ts` 0, `ev_ts` 0, state EMPTY. They take effect immediately on `rst` assertion, without a clock edge.
- Reset asserted mid-operation discards every buffered entry.
- Latency: `det` high at edge N gives `ev_valid` = 1 and `ev_ts` = `ts`(N) just after edge N. The same edge updates `ev_cnt`.
- No combinational path from `ev_ready` or `det` to any output; all outputs are registered or decoded from registers.
- Throughput: one push and one pop per cycle.

## Configuration
- `DET_EDGE_EN` defined:
  - `det` is registered into `det_q` (reset value 0; `clr` also sets it to 0).
  - The qualified `det` is `det & ~det_q`, so a run of consecutive high cycles produces one event.
- `DET_EDGE_EN` undefined: the qualified `det` is `det`, so every cycle sampled high is a separate event.

## Test plan
- After reset with `ev_ready` = 0, pulse `det` at ts = 3 and ts = 7. Expect `ev_valid` = 1 with `ev_ts` = 3. Then raise `ev_ready`: expect pops of 3 then 7, then `ev_valid` = 0, and `ev_cnt` = 2.
- DEPTH = 4, `ev_ready` = 0, 5 single-cycle events at ts = 1, 3, 5, 7, 9. Expect `full` = 1 after the 4th, the 5th dropped, `ovf` = 1 and `ev_cnt` = 5. Draining yields 1, 3, 5, 7.
- FIFO full, then `det` and `ev_ready` both 1 in one cycle. Expect the head popped and the new timestamp appended at the tail. `full` stays 1 and `ovf` stays 0.
- `clr` = 1 together with `det` = 1 while holding 2 entries with `ev_cnt` = 2. The next cycle shows `ev_valid` = 0, `ev_cnt` = 0, `ovf` = 0, `ts` = 0.
- Assert `rst` between clock edges with 3 entries held. Expect `ev_valid`, `full` and `ev_cnt` at 0 immediately, with no edge. With CNT_W = 2, 5 events give `ev_cnt` = 3.
- Hold `det` high for 3 cycles: 1 event with `DET_EDGE_EN`, 3 without. With TS_W = 4, events at ts = 15 and at the next cycle (ts = 0 after the wrap) give `ev_ts` = 15 then 0.
